// File: rtl/mdl_dmaseq_pkg.sv
// Shared types and constants for the 68000-bus DMA transfer sequencer.
package dmaseq_pkg;

  localparam int ADDR_W_DEF = 23;
  localparam int CNT_W_DEF  = 8;
  localparam int TO_W_DEF   = 8;

  // ROT8 bit that launches the address phase and the data-strobe phase
  localparam int PH_ADDR = 2;
  localparam int PH_DS   = 3;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_ACT,
    WAIT_PH,
    STROBE,
    WAIT_DTACK,
    NEGATE,
    END
  } state_e;

  // True only for a clean one-hot rotator sitting on the requested phase
  function automatic logic rot_at(input logic [7:0] rot, input int ph);
    return rot == 8'(1 << ph);
  endfunction

endpackage

// File: rtl/mdl_dmaseq_if.sv
// Bundle between the sequencer (master) and the buffer controller / bus frontend (slave).
interface mdl_dmaseq_if
  import dmaseq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
);
  logic              i_CLK4M_PCEN_n;
  logic [7:0]        i_ROT8;
  logic              i_REQ;
  logic              i_REQ_DIR;
  logic [CNT_W-1:0]  i_REQ_LEN;
  logic              i_ADDR_LD;
  logic [ADDR_W-1:0] i_ADDR_IN;
  logic              o_REQ_ACK;
  logic              o_BR_START_n;
  logic              i_DMA_ACT;
  logic              o_DMA_END;
  logic              i_DTACK_n;
  logic [ADDR_W-1:0] o_ADDR;
  logic              o_AS_n;
  logic              o_DS_n;
  logic              o_R_nW;
  logic              o_BUF_RD;
  logic              o_BUF_WR;
  logic              o_BUSY;
  logic              o_TIMEOUT;

  modport master (
    input  i_CLK4M_PCEN_n, i_ROT8, i_REQ, i_REQ_DIR, i_REQ_LEN, i_ADDR_LD, i_ADDR_IN,
           i_DMA_ACT, i_DTACK_n,
    output o_REQ_ACK, o_BR_START_n, o_DMA_END, o_ADDR, o_AS_n, o_DS_n, o_R_nW,
           o_BUF_RD, o_BUF_WR, o_BUSY, o_TIMEOUT
  );

  modport slave (
    output i_CLK4M_PCEN_n, i_ROT8, i_REQ, i_REQ_DIR, i_REQ_LEN, i_ADDR_LD, i_ADDR_IN,
           i_DMA_ACT, i_DTACK_n,
    input  o_REQ_ACK, o_BR_START_n, o_DMA_END, o_ADDR, o_AS_n, o_DS_n, o_R_nW,
           o_BUF_RD, o_BUF_WR, o_BUSY, o_TIMEOUT
  );
endinterface

// File: rtl/mdl_dmaseq_cnt.sv
// Word-address and remaining-length counters for one DMA burst.
module mdl_dmaseq_cnt #(
  parameter int ADDR_W = 23,
  parameter int CNT_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              addr_ld_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              len_ld_i,
  input  logic [CNT_W-1:0]  len_i,
  input  logic              step_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  len_q, len_d;

  // Address wraps naturally at 2^ADDR_W
  always_comb begin
    addr_d = addr_q;
    len_d  = len_q;
    if (addr_ld_i)   addr_d = addr_i;
    else if (step_i) addr_d = addr_q + ADDR_W'(1);
    if (len_ld_i)    len_d  = len_i;
    else if (step_i) len_d  = len_q - CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q <= '0;
      len_q  <= '0;
    end else if (en_i) begin
      addr_q <= addr_d;
      len_q  <= len_d;
    end
  end

  assign addr_o = addr_q;
  assign last_o = (len_q == CNT_W'(1));

endmodule

// File: rtl/mdl_dmaseq.sv
// DMA transfer sequencer: accepts a burst request, requests the bus, runs ROT8-phased
// 68000 word cycles and signals DMA_END so the frontend can release the bus.
module mdl_dmaseq
  import dmaseq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int TO_W   = TO_W_DEF
) (
  input  logic         i_MCLK,
  input  logic         i_SYS_RST,
  mdl_dmaseq_if.master bus
);

  localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};

  state_e          state_q;
  logic            dir_q;
  logic [TO_W-1:0] to_cnt_q;
  logic            ack_q, brs_n_q, as_n_q, ds_n_q, rnw_q;
  logic            buf_rd_q, buf_wr_q, end_q, timeout_q;

  logic en, in_burst, abort, addr_ld, len_ld, step, last;

  assign en       = ~bus.i_CLK4M_PCEN_n;
  assign in_burst = (state_q == WAIT_PH) || (state_q == STROBE) ||
                    (state_q == WAIT_DTACK) || (state_q == NEGATE);
  // Losing the bus mid-burst abandons the current word without advancing
  assign abort    = in_burst && !bus.i_DMA_ACT;
  assign addr_ld  = (state_q == IDLE) && bus.i_ADDR_LD;
  assign len_ld   = (state_q == IDLE) && bus.i_REQ && (bus.i_REQ_LEN != '0);
  assign step     = (state_q == NEGATE) && !timeout_q && !abort;

  mdl_dmaseq_cnt #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_cnt (
    .clk_i     (i_MCLK),
    .rst_i     (i_SYS_RST),
    .en_i      (en),
    .addr_ld_i (addr_ld),
    .addr_i    (bus.i_ADDR_IN),
    .len_ld_i  (len_ld),
    .len_i     (bus.i_REQ_LEN),
    .step_i    (step),
    .addr_o    (bus.o_ADDR),
    .last_o    (last)
  );

  always_ff @(posedge i_MCLK) begin
    if (i_SYS_RST) begin
      state_q   <= IDLE;
      dir_q     <= 1'b0;
      to_cnt_q  <= '0;
      ack_q     <= 1'b0;
      brs_n_q   <= 1'b1;
      as_n_q    <= 1'b1;
      ds_n_q    <= 1'b1;
      rnw_q     <= 1'b1;
      buf_rd_q  <= 1'b0;
      buf_wr_q  <= 1'b0;
      end_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else if (en) begin
      ack_q    <= 1'b0;
      brs_n_q  <= 1'b1;
      buf_rd_q <= 1'b0;
      buf_wr_q <= 1'b0;
      if (abort) begin
        state_q   <= IDLE;
        as_n_q    <= 1'b1;
        ds_n_q    <= 1'b1;
        rnw_q     <= 1'b1;
        timeout_q <= 1'b1;
      end else begin
        case (state_q)
          IDLE: if (bus.i_REQ) begin
            ack_q     <= 1'b1;
            timeout_q <= 1'b0;
            if (bus.i_REQ_LEN != '0) begin
              dir_q   <= bus.i_REQ_DIR;
              brs_n_q <= 1'b0;
              state_q <= WAIT_ACT;
            end
          end
          WAIT_ACT: if (bus.i_DMA_ACT) state_q <= WAIT_PH;
          WAIT_PH: if (rot_at(bus.i_ROT8, PH_ADDR)) begin
            rnw_q    <= ~dir_q;
            as_n_q   <= 1'b0;
            buf_rd_q <= dir_q;
            state_q  <= STROBE;
          end
          STROBE: if (rot_at(bus.i_ROT8, PH_DS)) begin
            ds_n_q   <= 1'b0;
            to_cnt_q <= '0;
            state_q  <= WAIT_DTACK;
          end
          WAIT_DTACK: if (!bus.i_DTACK_n) begin
            buf_wr_q <= ~dir_q;
            state_q  <= NEGATE;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
            if (to_cnt_q == TO_LAST) begin
              timeout_q <= 1'b1;
              state_q   <= NEGATE;
            end
          end
          NEGATE: begin
            as_n_q <= 1'b1;
            ds_n_q <= 1'b1;
            rnw_q  <= 1'b1;
            if (timeout_q || last) begin
              end_q   <= 1'b1;
              state_q <= END;
            end else begin
              state_q <= WAIT_PH;
            end
          end
          END: if (!bus.i_DMA_ACT) begin
            end_q   <= 1'b0;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.o_REQ_ACK    = ack_q;
  assign bus.o_BR_START_n = brs_n_q;
  assign bus.o_DMA_END    = end_q;
  assign bus.o_AS_n       = as_n_q;
  assign bus.o_DS_n       = ds_n_q;
  assign bus.o_R_nW       = rnw_q;
  assign bus.o_BUF_RD     = buf_rd_q;
  assign bus.o_BUF_WR     = buf_wr_q;
  assign bus.o_BUSY       = (state_q != IDLE);
  assign bus.o_TIMEOUT    = timeout_q;

endmodule

// File: tb/tb_mdl_dmaseq.sv
// Bench for mdl_dmaseq: timeline model of the burst protocol compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_mdl_dmaseq;
  import dmaseq_pkg::*;

  localparam int AW = 23;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   cmp_en  = 1'b0;
  int   dt_mode = 0;
  int   en_cnt  = 0;

  mdl_dmaseq_if #(.ADDR_W(AW), .CNT_W(CW)) bus();

  mdl_dmaseq dut (
    .i_MCLK    (clk),
    .i_SYS_RST (rst),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s @%0t: got %0h, want %0h", nm, $time, act, exp);
    end
  endtask

  // Enable every other MCLK; the rotator advances once per enable
  initial begin
    bit was;
    bus.i_CLK4M_PCEN_n = 1'b1;
    bus.i_ROT8 = 8'h01;
    forever begin
      @(posedge clk);
      was = (bus.i_CLK4M_PCEN_n == 1'b0);
      #1;
      if (was) begin
        bus.i_ROT8 = {bus.i_ROT8[6:0], bus.i_ROT8[7]};
        en_cnt++;
        bus.i_CLK4M_PCEN_n = 1'b1;
      end else begin
        bus.i_CLK4M_PCEN_n = 1'b0;
      end
    end
  end

  // Bus slave: 0 = DTACK always low, 1 = never, 2 = low after 10 enables of DS
  initial begin
    bit was;
    int dcnt;
    dcnt = 0;
    bus.i_DTACK_n = 1'b1;
    forever begin
      @(posedge clk);
      was = (bus.i_CLK4M_PCEN_n == 1'b0);
      #1;
      if (was) dcnt = (bus.o_DS_n === 1'b0) ? dcnt + 1 : 0;
      case (dt_mode)
        0:       bus.i_DTACK_n = 1'b0;
        1:       bus.i_DTACK_n = 1'b1;
        default: bus.i_DTACK_n = (dcnt >= 10) ? 1'b0 : 1'b1;
      endcase
    end
  end

  // ---------------- behavioural model ----------------
  logic          exp_ack, exp_brs_n, exp_as_n, exp_ds_n, exp_rnw;
  logic          exp_rd, exp_wr, exp_end, exp_busy, exp_to;
  logic [AW-1:0] exp_addr;

  task automatic ev();
    do @(posedge clk); while (bus.i_CLK4M_PCEN_n !== 1'b0);
    exp_ack = 1'b0; exp_brs_n = 1'b1; exp_rd = 1'b0; exp_wr = 1'b0;
  endtask

  task automatic run_burst(input bit dir, input int len);
    int hi;
    bit ok;
    exp_brs_n = 1'b0;
    exp_busy  = 1'b1;
    do ev(); while (!bus.i_DMA_ACT);
    for (int w = 0; w < len; w++) begin
      do ev(); while (bus.i_ROT8 != 8'h04);
      exp_as_n = 1'b0; exp_rnw = ~dir; exp_rd = dir;
      do ev(); while (bus.i_ROT8 != 8'h08);
      exp_ds_n = 1'b0;
      hi = 0;
      ok = 1'b0;
      forever begin
        ev();
        if (!bus.i_DTACK_n) begin
          ok = 1'b1;
          exp_wr = ~dir;
          break;
        end
        hi++;
        if (hi == 255) begin
          exp_to = 1'b1;
          break;
        end
      end
      ev();
      exp_as_n = 1'b1; exp_ds_n = 1'b1; exp_rnw = 1'b1;
      if (ok) exp_addr = exp_addr + 1'b1;
      if (!ok) break;
    end
    exp_end = 1'b1;
    do ev(); while (bus.i_DMA_ACT);
    exp_end  = 1'b0;
    exp_busy = 1'b0;
  endtask

  initial begin
    exp_ack = 0; exp_brs_n = 1; exp_as_n = 1; exp_ds_n = 1; exp_rnw = 1;
    exp_rd = 0; exp_wr = 0; exp_end = 0; exp_busy = 0; exp_to = 0; exp_addr = '0;
    wait (rst == 1'b0);
    forever begin
      ev();
      if (bus.i_ADDR_LD) exp_addr = bus.i_ADDR_IN;
      if (bus.i_REQ) begin
        exp_ack = 1'b1;
        exp_to  = 1'b0;
        if (bus.i_REQ_LEN != '0) run_burst(bus.i_REQ_DIR, int'(bus.i_REQ_LEN));
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      chk("cyc_req_ack",    32'(bus.o_REQ_ACK),    32'(exp_ack));
      chk("cyc_br_start_n", 32'(bus.o_BR_START_n), 32'(exp_brs_n));
      chk("cyc_as_n",       32'(bus.o_AS_n),       32'(exp_as_n));
      chk("cyc_ds_n",       32'(bus.o_DS_n),       32'(exp_ds_n));
      chk("cyc_r_nw",       32'(bus.o_R_nW),       32'(exp_rnw));
      chk("cyc_buf_rd",     32'(bus.o_BUF_RD),     32'(exp_rd));
      chk("cyc_buf_wr",     32'(bus.o_BUF_WR),     32'(exp_wr));
      chk("cyc_dma_end",    32'(bus.o_DMA_END),    32'(exp_end));
      chk("cyc_busy",       32'(bus.o_BUSY),       32'(exp_busy));
      chk("cyc_timeout",    32'(bus.o_TIMEOUT),    32'(exp_to));
      chk("cyc_addr",       32'(bus.o_ADDR),       32'(exp_addr));
    end
  end

  // ---------------- event monitor ----------------
  int n_br = 0, n_wr = 0, n_rd = 0, n_ack = 0, busy_cnt = 0, ds_en = 0, to_en = 0;
  logic [AW-1:0] as_addr[$];
  int            as_en[$];
  bit            as_rnw[$];
  bit            as_rd[$];

  initial begin
    logic p_br, p_wr, p_rd, p_ack, p_as, p_ds, p_to;
    p_br = 1; p_wr = 0; p_rd = 0; p_ack = 0; p_as = 1; p_ds = 1; p_to = 0;
    forever begin
      @(negedge clk);
      if (p_br === 1'b1 && bus.o_BR_START_n === 1'b0) n_br++;
      if (p_wr === 1'b0 && bus.o_BUF_WR === 1'b1) n_wr++;
      if (p_rd === 1'b0 && bus.o_BUF_RD === 1'b1) n_rd++;
      if (p_ack === 1'b0 && bus.o_REQ_ACK === 1'b1) n_ack++;
      if (bus.o_BUSY === 1'b1) busy_cnt++;
      if (p_ds === 1'b1 && bus.o_DS_n === 1'b0) ds_en = en_cnt;
      if (p_to === 1'b0 && bus.o_TIMEOUT === 1'b1) to_en = en_cnt;
      if (p_as === 1'b1 && bus.o_AS_n === 1'b0) begin
        as_addr.push_back(bus.o_ADDR);
        as_en.push_back(en_cnt);
        as_rnw.push_back(bus.o_R_nW);
        as_rd.push_back(bus.o_BUF_RD);
      end
      p_br = bus.o_BR_START_n; p_wr = bus.o_BUF_WR; p_rd = bus.o_BUF_RD;
      p_ack = bus.o_REQ_ACK; p_as = bus.o_AS_n; p_ds = bus.o_DS_n; p_to = bus.o_TIMEOUT;
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_en();
    do @(posedge clk); while (bus.i_CLK4M_PCEN_n !== 1'b0);
    #2;
  endtask

  task automatic wait_ens(input int n);
    for (int i = 0; i < n; i++) wait_en();
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_ack"},   32'(bus.o_REQ_ACK),    32'd0);
    chk({tag, "_br_n"},  32'(bus.o_BR_START_n), 32'd1);
    chk({tag, "_as_n"},  32'(bus.o_AS_n),       32'd1);
    chk({tag, "_ds_n"},  32'(bus.o_DS_n),       32'd1);
    chk({tag, "_r_nw"},  32'(bus.o_R_nW),       32'd1);
    chk({tag, "_rd"},    32'(bus.o_BUF_RD),     32'd0);
    chk({tag, "_wr"},    32'(bus.o_BUF_WR),     32'd0);
    chk({tag, "_end"},   32'(bus.o_DMA_END),    32'd0);
    chk({tag, "_busy"},  32'(bus.o_BUSY),       32'd0);
    chk({tag, "_to"},    32'(bus.o_TIMEOUT),    32'd0);
    chk({tag, "_addr"},  32'(bus.o_ADDR),       32'd0);
  endtask

  // Request one burst, play the frontend (grant after 2 enables, release after DMA_END)
  task automatic run(input string tag, input bit dir, input int len, input bit ld,
                     input logic [AW-1:0] addr, input int max_en);
    int k;
    bus.i_REQ = 1'b1; bus.i_REQ_DIR = dir; bus.i_REQ_LEN = CW'(len);
    bus.i_ADDR_LD = ld; bus.i_ADDR_IN = addr;
    wait_en();
    bus.i_REQ = 1'b0; bus.i_ADDR_LD = 1'b0;
    wait_ens(2);
    bus.i_DMA_ACT = 1'b1;
    k = 0;
    while (bus.o_DMA_END !== 1'b1 && k < max_en) begin
      wait_en();
      k++;
    end
    chk({tag, "_dma_end_seen"}, 32'(bus.o_DMA_END), 32'd1);
    wait_ens(2);
    bus.i_DMA_ACT = 1'b0;
    wait_ens(3);
  endtask

  initial begin
    int b_br, b_wr, b_rd, b_ack, b_busy, b_as, k;
    bus.i_REQ = 0; bus.i_REQ_DIR = 0; bus.i_REQ_LEN = '0;
    bus.i_ADDR_LD = 0; bus.i_ADDR_IN = '0; bus.i_DMA_ACT = 0;

    repeat (4) @(posedge clk);
    #1;
    check_reset("rst0");
    #1;
    rst = 1'b0;
    cmp_en = 1'b1;
    wait_ens(3);

    // 1: read burst of 3 at 0x100, DTACK immediate; load and request in the same enable
    dt_mode = 0;
    b_br = n_br; b_wr = n_wr; b_as = as_addr.size();
    run("t1", 1'b0, 3, 1'b1, 23'h000100, 200);
    chk("t1_br_pulses", 32'(n_br - b_br), 32'd1);
    chk("t1_buf_wr",    32'(n_wr - b_wr), 32'd3);
    chk("t1_addr0",     32'(as_addr[b_as]),     32'h100);
    chk("t1_addr1",     32'(as_addr[b_as + 1]), 32'h101);
    chk("t1_addr2",     32'(as_addr[b_as + 2]), 32'h102);
    chk("t1_rnw",       32'(as_rnw[b_as]),      32'd1);
    chk("t1_spacing",   32'(as_en[b_as + 1] - as_en[b_as]), 32'd8);
    chk("t1_end_addr",  32'(bus.o_ADDR), 32'h103);

    // 2: write burst of 1 at the top address, wraps to 0
    bus.i_ADDR_LD = 1'b1; bus.i_ADDR_IN = 23'h7FFFFF;
    wait_en();
    bus.i_ADDR_LD = 1'b0;
    b_rd = n_rd; b_wr = n_wr; b_as = as_addr.size();
    run("t2", 1'b1, 1, 1'b0, 23'h0, 200);
    chk("t2_addr_at_as", 32'(as_addr[b_as]), 32'h7FFFFF);
    chk("t2_rd_with_as", 32'(as_rd[b_as]),   32'd1);
    chk("t2_rnw",        32'(as_rnw[b_as]),  32'd0);
    chk("t2_buf_rd",     32'(n_rd - b_rd),   32'd1);
    chk("t2_buf_wr",     32'(n_wr - b_wr),   32'd0);
    chk("t2_wrap_addr",  32'(bus.o_ADDR),    32'h0);

    // 3: DTACK never arrives -> timeout after 255 enables, address kept
    dt_mode = 1;
    b_as = as_addr.size();
    run("t3", 1'b0, 2, 1'b1, 23'h000200, 600);
    chk("t3_timeout",    32'(bus.o_TIMEOUT),     32'd1);
    chk("t3_to_latency", 32'(to_en - ds_en),     32'd255);
    chk("t3_addr",       32'(bus.o_ADDR),        32'h200);
    chk("t3_words",      32'(as_addr.size() - b_as), 32'd1);
    chk("t3_as_n",       32'(bus.o_AS_n),        32'd1);
    dt_mode = 0;

    // 4: zero-length request: ACK only, clears sticky timeout
    b_ack = n_ack; b_br = n_br; b_busy = busy_cnt;
    bus.i_REQ = 1'b1; bus.i_REQ_LEN = '0; bus.i_REQ_DIR = 1'b0;
    wait_en();
    bus.i_REQ = 1'b0;
    wait_ens(3);
    chk("t4_ack",     32'(n_ack - b_ack),     32'd1);
    chk("t4_br",      32'(n_br - b_br),       32'd0);
    chk("t4_busy",    32'(busy_cnt - b_busy), 32'd0);
    chk("t4_to_clr",  32'(bus.o_TIMEOUT),     32'd0);

    // 6: DTACK 10 enables after DS, two words
    dt_mode = 2;
    b_wr = n_wr; b_as = as_addr.size();
    run("t6", 1'b0, 2, 1'b1, 23'h000300, 300);
    chk("t6_spacing",  32'(as_en[b_as + 1] - as_en[b_as]), 32'd16);
    chk("t6_addr1",    32'(as_addr[b_as + 1]), 32'h301);
    chk("t6_end_addr", 32'(bus.o_ADDR),        32'h302);
    chk("t6_buf_wr",   32'(n_wr - b_wr),       32'd2);

    // 5: reset while waiting for DTACK
    dt_mode = 1;
    bus.i_REQ = 1'b1; bus.i_REQ_LEN = CW'(2); bus.i_REQ_DIR = 1'b0;
    bus.i_ADDR_LD = 1'b1; bus.i_ADDR_IN = 23'h000400;
    wait_en();
    bus.i_REQ = 1'b0; bus.i_ADDR_LD = 1'b0;
    wait_ens(2);
    bus.i_DMA_ACT = 1'b1;
    k = 0;
    while (bus.o_DS_n !== 1'b0 && k < 50) begin
      wait_en();
      k++;
    end
    chk("t5_ds_low", 32'(bus.o_DS_n), 32'd0);
    wait_ens(3);
    cmp_en = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset("t5");
    rst = 1'b0;
    bus.i_DMA_ACT = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1);
  end

endmodule
